// File: rtl/counter_monitor.sv
// -----------------------------------------------------------------------------
// counter_monitor
//
// Passive checker for a W-bit up/down step counter. Each rising edge it samples
// the counter value together with the step/down controls that drove it. From
// that sample it predicts the value the counter must show one edge later, and
// it flags any difference. It also counts wrap-around events for display. It
// never drives the counter.
//
// Ports
//   clk    in   1   counter clock; all state changes on its rising edge
//   nrst   in   1   asynchronous active-low reset
//   cnt    in   W   counter output under observation
//   step   in   1   counter control: 1 = step by 2, 0 = step by 1
//   down   in   1   counter control: 1 = count down, 0 = count up
//   clr    in   1   synchronous clear of err/errs/wraps/wrap and of FAULT
//   err    out  1   sticky mismatch flag
//   errs   out  EW  saturating mismatch count
//   wrap   out  1   one-cycle pulse per wrap-around
//   wraps  out  CW  wrap count, modulo 2^CW
//   valid  out  1   high once predictions are being checked (state not INIT)
// -----------------------------------------------------------------------------
module counter_monitor #(
  parameter int W  = 4,
  parameter int CW = 8,
  parameter int EW = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [W-1:0]  cnt,
  input  logic          step,
  input  logic          down,
  input  logic          clr,
  output logic          err,
  output logic [EW-1:0] errs,
  output logic          wrap,
  output logic [CW-1:0] wraps,
  output logic          valid
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  pv_q, pv_d;
  logic          ps_q, ps_d;
  logic          pd_q, pd_d;
  logic          err_q, err_d;
  logic [EW-1:0] errs_q, errs_d;
  logic          wrap_q, wrap_d;
  logic [CW-1:0] wraps_q, wraps_d;

  // Prediction datapath. It works on the previous sample only. The delta is
  // one bit wider than the counter, so the carry out of the up-sum is the up
  // wrap condition.
  logic [W:0]   delta;
  logic [W:0]   sum_up;
  logic [W-1:0] exp_val;
  logic         wrap_cond;
  logic         mismatch;

  always_comb begin
    delta     = ps_q ? (W+1)'(2) : (W+1)'(1);
    sum_up    = {1'b0, pv_q} + delta;
    exp_val   = pd_q ? (pv_q - delta[W-1:0]) : sum_up[W-1:0];
    wrap_cond = pd_q ? ({1'b0, pv_q} < delta) : sum_up[W];
    mismatch  = (cnt != exp_val);
  end

  // Next-state and output logic.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d = state_q;
    err_d   = err_q;
    errs_d  = errs_q;
    wrap_d  = 1'b0;
    wraps_d = wraps_q;

    // The sample registers load on every edge, clr included. Checking can
    // then resume on the edge right after a clear.
    pv_d = cnt;
    ps_d = step;
    pd_d = down;

    if (clr) begin
      // clr overrides any compare or wrap result from the same edge.
      err_d   = 1'b0;
      errs_d  = '0;
      wraps_d = '0;
      state_d = (state_q == S_INIT) ? S_INIT : S_TRACK;
    end else begin
      unique case (state_q)
        S_INIT: begin
          // The first edge after reset only captures. There is no valid
          // previous sample yet.
          state_d = S_TRACK;
        end
        S_TRACK, S_FAULT: begin
          if (mismatch) begin
            err_d   = 1'b1;
            errs_d  = (errs_q == '1) ? errs_q : errs_q + EW'(1);
            state_d = S_FAULT;
          end
          // Wraps are reported whether or not the value matched.
          if (wrap_cond) begin
            wrap_d  = 1'b1;
            wraps_d = wraps_q + CW'(1);
          end
        end
        default: begin
          state_d = S_INIT;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then updates from the values that held before the edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_INIT;
      pv_q    <= '0;
      ps_q    <= 1'b0;
      pd_q    <= 1'b0;
      err_q   <= 1'b0;
      errs_q  <= '0;
      wrap_q  <= 1'b0;
      wraps_q <= '0;
    end else begin
      state_q <= state_d;
      pv_q    <= pv_d;
      ps_q    <= ps_d;
      pd_q    <= pd_d;
      err_q   <= err_d;
      errs_q  <= errs_d;
      wrap_q  <= wrap_d;
      wraps_q <= wraps_d;
    end
  end

  assign err   = err_q;
  assign errs  = errs_q;
  assign wrap  = wrap_q;
  assign wraps = wraps_q;
  assign valid = (state_q != S_INIT);

endmodule

// File: tb/tb_counter_monitor.sv
// -----------------------------------------------------------------------------
// tb_counter_monitor
//
// Directed bench for counter_monitor with the default widths (W=4, CW=8,
// EW=4). The bench plays the part of the monitored counter. It drives cnt
// with the value a correct counter would show, or with a deliberately wrong
// value. Each step waits for a rising edge and samples 1 ns after it, then
// presents the counter value that follows that edge.
// -----------------------------------------------------------------------------
module tb_counter_monitor;

  logic       clk;
  logic       nrst;
  logic [3:0] cnt;
  logic       step;
  logic       down;
  logic       clr;
  logic       err;
  logic [3:0] errs;
  logic       wrap;
  logic [7:0] wraps;
  logic       valid;

  int n_cmp;
  int n_bad;

  counter_monitor #(.W(4), .CW(8), .EW(4)) dut (
    .clk   (clk),
    .nrst  (nrst),
    .cnt   (cnt),
    .step  (step),
    .down  (down),
    .clr   (clr),
    .err   (err),
    .errs  (errs),
    .wrap  (wrap),
    .wraps (wraps),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One rising edge, then a short settle before the outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between edges. The counter restarts at 0 while reset
  // is held. Release happens on a falling edge.
  task automatic do_reset();
    nrst = 1'b0;
    cnt  = 4'd0;
    step = 1'b0;
    down = 1'b0;
    clr  = 1'b0;
    #2;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nrst  = 1'b1;
    cnt   = 4'd0;
    step  = 1'b0;
    down  = 1'b0;
    clr   = 1'b0;
    #1;
    nrst  = 1'b0;
    #1;

    // ---- reset values ----
    check("rst_err",   err,   0);
    check("rst_errs",  errs,  0);
    check("rst_wrap",  wrap,  0);
    check("rst_wraps", wraps, 0);
    check("rst_valid", valid, 0);

    // ---- count up by 1 from 0: the only wrap is the 15->0 compare (edge 17) ----
    do_reset();
    for (int i = 1; i <= 18; i++) begin
      tick();
      check("up1_valid", valid, 1);
      check("up1_err",   err,   0);
      check("up1_wrap",  wrap,  (i == 17) ? 1 : 0);
      cnt = cnt + 4'd1;
    end
    check("up1_wraps", wraps, 1);

    // ---- count down by 2 from 0: 14,12,...,0,14; wraps at edges 2, 10, 18 ----
    do_reset();
    step = 1'b1;
    down = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      tick();
      check("dn2_err",  err,  0);
      check("dn2_wrap", wrap, (i == 2 || i == 10 || i == 18) ? 1 : 0);
      cnt = cnt - 4'd2;
    end
    check("dn2_wraps", wraps, 3);

    // ---- mismatch: show 5 when 4 is expected, then a second bad value ----
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      tick();
      cnt = cnt + 4'd1;
    end
    check("mm_pre_err", err, 0);
    cnt = 4'd5;                      // a correct counter would show 4
    tick();
    check("mm1_err",   err,   1);
    check("mm1_errs",  errs,  1);
    check("mm1_valid", valid, 1);
    cnt = 4'd6;                      // correct follow-on from 5
    tick();
    check("mm_ok_errs", errs, 1);
    check("mm_ok_err",  err,  1);
    cnt = 4'd9;                      // a correct counter would show 7
    tick();
    check("mm2_errs", errs, 2);
    check("mm2_err",  err,  1);
    cnt = 4'd10;
    tick();
    check("mm3_errs", errs, 2);
    check("mm3_err",  err,  1);

    // ---- 20 mismatches with cnt stuck at 0: errs saturates at 15 ----
    do_reset();
    tick();
    check("sat_init_errs", errs, 0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("sat_errs", errs, (i < 15) ? i : 15);
    end
    check("sat_err",  err,  1);
    check("sat_wrap", wrap, 0);

    // ---- clr in FAULT while the wrap condition holds ----
    // cnt stays at 0 with down=1. From edge B on, every compare both wraps and
    // mismatches.
    down = 1'b1;
    tick();                          // edge A: previous sample was up, no wrap
    check("clr_a_wrap", wrap, 0);
    check("clr_a_errs", errs, 15);
    tick();                          // edge B
    check("clr_b_wrap",  wrap,  1);
    check("clr_b_wraps", wraps, 1);
    check("clr_b_err",   err,   1);
    tick();                          // edge C
    check("clr_c_wraps", wraps, 2);
    clr = 1'b1;
    tick();                          // edge D: clear wins over wrap and mismatch
    check("clr_d_err",   err,   0);
    check("clr_d_errs",  errs,  0);
    check("clr_d_wraps", wraps, 0);
    check("clr_d_wrap",  wrap,  0);
    check("clr_d_valid", valid, 1);
    clr = 1'b0;
    cnt = 4'd15;                     // correct step down from 0
    tick();                          // edge E
    check("clr_e_err",   err,   0);
    check("clr_e_errs",  errs,  0);
    check("clr_e_wrap",  wrap,  1);
    check("clr_e_wraps", wraps, 1);
    cnt = 4'd14;

    // ---- count down to 9, then reset mid-run ----
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("pre_rst_err",  err,  0);
      check("pre_rst_wrap", wrap, 0);
      cnt = cnt - 4'd1;
    end
    check("pre_rst_cnt_valid", valid, 1);
    check("pre_rst_wraps",     wraps, 1);
    nrst = 1'b0;                     // cnt is showing 9 here
    cnt  = 4'd0;
    down = 1'b0;
    #2;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_wraps", wraps, 0);
    check("mid_rst_err",   err,   0);
    check("mid_rst_errs",  errs,  0);
    check("mid_rst_wrap",  wrap,  0);
    @(negedge clk);
    nrst = 1'b1;
    tick();                          // capture only: 0 is not compared against 1
    check("post_rst_valid", valid, 1);
    check("post_rst_err",   err,   0);
    check("post_rst_errs",  errs,  0);
    cnt = 4'd1;
    tick();
    check("post_rst_err1", err, 0);
    cnt = 4'd2;
    tick();
    check("post_rst_err2", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
